decode_issue_stage: RTL and testbench
=====================================

Name: decode_issue_stage

Overview:
- Decode stage sitting directly upstream of the 8x16 register file.
- Accepts fetched 16-bit instructions over a valid/ready handshake and splits out the register fields.
- Drives the register-file read addresses and write-back ownership.
- Blocks RAW/WAW hazards with an 8-entry pending-write scoreboard, then hands decoded fields to execute one cycle later, aligned with BusA/BusB.

Parameters:
- INSTR_W, 16, instruction width
- REG_AW, 3, register address width
- NREG, 8, register count (2**REG_AW)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_instr  in  16  instruction word
- in_ready  out  1  stage accepts in_instr this cycle
- rf_ra  out  3  register-file RA
- rf_rb  out  3  register-file RB
- out_valid  out  1  decoded instruction valid (BusA/BusB valid same cycle)
- out_ready  in  1  execute consumes this cycle
- out_opcode  out  4  opcode
- out_rd  out  3  destination register
- out_func  out  3  function/immediate field
- out_wr  out  1  instruction writes Rd
- wb_en  in  1  write-back stage commits a register write this cycle
- wb_rd  in  3  register being written back
- flush  in  1  kill the instruction held in the output register and any input this cycle

Behaviour:
- Field layout:
  - opcode = instr[15:12]
  - rd = [11:9]
  - rs1 = [8:6]
  - rs2 = [5:3]
  - func = [2:0]
- Writes-Rd rule: wr = (opcode in 0x1..0x7) and rd != 0.
  - Opcode 0x0 is NOP.
  - Opcodes 0x8..0xF never write.
- Reset (async, rst_n low):
  - out_valid = 0, out_opcode/out_rd/out_func = 0, out_wr = 0.
  - Scoreboard pending[7:0] = 0.
  - owned flag = 0.
- Hazard:
  - hz = pending[rs1] or pending[rs2] or (wr and pending[rd]).
  - R0 is never pending.
- Acceptance:
  - in_ready = !hz and (!out_valid or out_ready) and !flush.
  - accept = in_valid and in_ready.
- Read addresses:
  - rf_ra/rf_rb = rs1/rs2 of in_instr when accept.
  - Otherwise rs1/rs2 of the held output instruction, so the register file re-reads the same operands every stalled cycle.
- Latency: one cycle. An instruction accepted at edge N sets out_valid after edge N; BusA/BusB are captured at the same edge.
- Output register:
  - Loads on accept.
  - Clears out_valid on (out_ready and !accept) or flush.
  - Holds otherwise.
- Scoreboard:
  - Set: on accept with wr, pending[rd] <= 1.
  - Clear: on wb_en, pending[wb_rd] <= 0.
  - Same register set and cleared in the same cycle: set wins.
  - No bypass. A clear takes effect the next cycle, so the source is read after the register-file write has landed.
- Flush:
  - If out_valid and out_wr for the held instruction, pending[out_rd] is cleared, unless wb_en targets the same register in that cycle (clear is idempotent).
  - Input is not accepted during flush.
  - Flush with out_valid = 0 has no effect beyond blocking input.
- Reset mid-operation drops the held instruction and all pending bits immediately.

Optional Feature:
- Macro DECODE_STALL_COUNT_EN.
- Defined:
  - Adds output port stall_count (16 bits).
  - Increments every cycle with in_valid=1 and hz=1.
  - Saturates at 0xFFFF.
  - Reset to 0.
- Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - Opcode constants (OP_NOP=0x0, ALU/load range 0x1..0x7, store/branch/jump 0x8..0xF).
  - Field bit-position constants.
  - REG_AW/INSTR_W.
  - The writes-Rd function.
- One sub-module, reg_scoreboard:
  - 8-bit pending vector with set/clear/flush-clear ports.
  - Combinational lookup of three addresses.
  - Set-over-clear priority.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, in_ready reflects empty scoreboard, no pending bits. Release -> first instruction 0x1298 issues: rd=1, rs1=2, rs2=3, out_valid one cycle later.
- RAW stall: issue 0x1298 (writes R1), then 0x2440 (rs1=R1) -> in_ready=0 and rf_ra held. Pulse wb_en, wb_rd=1 -> accepted the cycle after the clear.
- R0 immunity: 0x1000 (rd=0), then 0x2000 (rs1=R0) -> no stall, pending stays 0x00.
- Back-pressure: out_ready=0 for 3 cycles with out_valid=1 -> out fields and rf_ra/rf_rb stable, in_ready=0. Raise out_ready -> next instruction accepted that cycle.
- Simultaneous set/clear: accept a writer of R4 in the same cycle as wb_en, wb_rd=4 -> pending[4]=1 afterwards.
- Flush: held 0x1A00 (rd=5), assert flush -> out_valid=0, pending[5]=0, in_instr not accepted that cycle.
- Stall counter (with DECODE_STALL_COUNT_EN): 5 hazard cycles -> stall_count=5.

Source files
------------

// File: rtl/decode_issue_stage_pkg.sv
// Shared decode definitions for the decode/issue stage.
// Field positions, opcode ranges and the writes-Rd rule.
package decode_issue_stage_pkg;

    localparam int INSTR_W = 16;
    localparam int REG_AW  = 3;
    localparam int NREG    = 2 ** REG_AW;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ALU_LO = 4'h1;
    localparam logic [3:0] OP_ALU_HI = 4'h7;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int FN_LSB  = 0;

    typedef struct packed {
        logic [3:0]        opcode;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [2:0]        func;
    } fields_t;

    function automatic fields_t decode(input logic [INSTR_W-1:0] instr);
        fields_t f;
        f.opcode = instr[OP_LSB  +: 4];
        f.rd     = instr[RD_LSB  +: REG_AW];
        f.rs1    = instr[RS1_LSB +: REG_AW];
        f.rs2    = instr[RS2_LSB +: REG_AW];
        f.func   = instr[FN_LSB  +: 3];
        return f;
    endfunction

    // R0 is hardwired, so a write to it never needs tracking.
    function automatic logic writes_rd(input logic [3:0]        op,
                                       input logic [REG_AW-1:0] rd);
        return (op >= OP_ALU_LO) && (op <= OP_ALU_HI) && (rd != '0);
    endfunction

endpackage

// File: rtl/decode_issue_stage_reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set beats clear.
// Three combinational lookups for rs1, rs2 and rd.
module reg_scoreboard
    import decode_issue_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_rd,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_rd,
    input  logic              fl_en,
    input  logic [REG_AW-1:0] fl_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    output logic              hit1,
    output logic              hit2,
    output logic              hit_rd,
    output logic [NREG-1:0]   pending
);

    logic [NREG-1:0] nxt;

    always_comb begin
        nxt = pending;
        if (clr_en) nxt[clr_rd] = 1'b0;
        if (fl_en)  nxt[fl_rd]  = 1'b0;
        if (set_en) nxt[set_rd] = 1'b1;
        nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= nxt;
    end

    assign hit1   = pending[rs1];
    assign hit2   = pending[rs2];
    assign hit_rd = pending[rd];

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage in front of the 8x16 register file.
// Optional stall counter: define DECODE_STALL_COUNT_EN.
module decode_issue_stage
    import decode_issue_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    output logic [REG_AW-1:0]  rf_ra,
    output logic [REG_AW-1:0]  rf_rb,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_opcode,
    output logic [REG_AW-1:0]  out_rd,
    output logic [2:0]         out_func,
    output logic               out_wr,
    input  logic               wb_en,
    input  logic [REG_AW-1:0]  wb_rd,
    input  logic               flush
`ifdef DECODE_STALL_COUNT_EN
    ,
    output logic [15:0]        stall_count
`endif
);

    fields_t           f;
    logic              wr_in;
    logic              hit1;
    logic              hit2;
    logic              hit_rd;
    logic              hz;
    logic              accept;
    logic [REG_AW-1:0] hold_rs1;
    logic [REG_AW-1:0] hold_rs2;
    logic [NREG-1:0]   pending;

    assign f      = decode(in_instr);
    assign wr_in  = writes_rd(f.opcode, f.rd);
    assign hz     = hit1 | hit2 | (wr_in & hit_rd);
    assign in_ready = !hz && (!out_valid || out_ready) && !flush;
    assign accept = in_valid && in_ready;

    // Stalled cycles keep re-reading the held operands.
    assign rf_ra = accept ? f.rs1 : hold_rs1;
    assign rf_rb = accept ? f.rs2 : hold_rs2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_opcode <= OP_NOP;
            out_rd     <= '0;
            out_func   <= '0;
            out_wr     <= 1'b0;
            hold_rs1   <= '0;
            hold_rs2   <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_opcode <= f.opcode;
            out_rd     <= f.rd;
            out_func   <= f.func;
            out_wr     <= wr_in;
            hold_rs1   <= f.rs1;
            hold_rs2   <= f.rs2;
        end else if (flush || out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    reg_scoreboard u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (accept && wr_in),
        .set_rd  (f.rd),
        .clr_en  (wb_en),
        .clr_rd  (wb_rd),
        .fl_en   (flush && out_valid && out_wr),
        .fl_rd   (out_rd),
        .rs1     (f.rs1),
        .rs2     (f.rs2),
        .rd      (f.rd),
        .hit1    (hit1),
        .hit2    (hit2),
        .hit_rd  (hit_rd),
        .pending (pending)
    );

`ifdef DECODE_STALL_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (in_valid && hz && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_decode_issue_stage.sv
// Self-checking bench for decode_issue_stage.
// Expected issue bundles are queued on accept and popped at output.
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic [2:0]  rf_ra;
    logic [2:0]  rf_rb;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [2:0]  out_rd;
    logic [2:0]  out_func;
    logic        out_wr;
    logic        wb_en;
    logic [2:0]  wb_rd;
    logic        flush;
`ifdef DECODE_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    int errors = 0;
    int checks = 0;
    int stalls = 0;
    logic [10:0] exp_q[$];

    always #5 clk = ~clk;

    decode_issue_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .rf_ra      (rf_ra),
        .rf_rb      (rf_rb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_rd     (out_rd),
        .out_func   (out_func),
        .out_wr     (out_wr),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .flush      (flush)
`ifdef DECODE_STALL_COUNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] model(input logic [15:0] i);
        logic [3:0] op;
        logic [2:0] rd;
        logic       wr;
        op = i[15:12];
        rd = i[11:9];
        wr = (op >= 4'h1) && (op <= 4'h7) && (rd != 3'd0);
        return {op, rd, i[2:0], wr};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && (flush || out_ready)) begin
            if (exp_q.size() == 0) begin
                chk("q_underflow", 32'd1, 32'd0);
            end else if (flush) begin
                void'(exp_q.pop_front());
            end else begin
                chk("issue", {out_opcode, out_rd, out_func, out_wr},
                    exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [15:0] i, input logic v,
                         input logic rdy, input logic hz,
                         input logic [2:0] ra, input logic [2:0] rb);
        in_instr = i;
        in_valid = v;
        @(negedge clk);
        chk("in_ready", in_ready, rdy);
        chk("rf_ra", rf_ra, ra);
        chk("rf_rb", rf_rb, rb);
        if (v && rdy) exp_q.push_back(model(i));
        if (v && hz) stalls++;
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [2:0] r);
        wb_en = 1'b1;
        wb_rd = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_instr = 16'h1298;
        out_ready = 1'b1;
        wb_en = 1'b0;
        wb_rd = '0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ov", out_valid, 1'b0);
        chk("rst_rdy", in_ready, 1'b1);
        chk("rst_pend", dut.u_sb.pending, 8'h00);
        chk("rst_out", {out_opcode, out_rd, out_func, out_wr}, 11'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        drive(16'h1298, 1, 1, 0, 3'd2, 3'd3);
        drive(16'h2440, 1, 0, 1, 3'd2, 3'd3);
        drive(16'h2440, 1, 0, 1, 3'd2, 3'd3);
        wb(3'd1);
        drive(16'h2440, 1, 0, 1, 3'd2, 3'd3);
        wb_en = 1'b0;
        drive(16'h2440, 1, 1, 0, 3'd1, 3'd0);
        chk("pend_r2", dut.u_sb.pending, 8'h04);
        wb(3'd2);
        drive(16'h0000, 0, 1, 0, 3'd1, 3'd0);
        wb_en = 1'b0;
        chk("pend_clr", dut.u_sb.pending, 8'h00);

        drive(16'h1000, 1, 1, 0, 3'd0, 3'd0);
        drive(16'h2000, 1, 1, 0, 3'd0, 3'd0);
        chk("pend_r0", dut.u_sb.pending, 8'h00);

        drive(16'h3298, 1, 1, 0, 3'd2, 3'd3);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(16'h4000, 1, 0, 0, 3'd2, 3'd3);
            chk("bp_hold", {out_valid, out_opcode, out_rd}, {1'b1, 4'h3, 3'd1});
        end
        out_ready = 1'b1;
        drive(16'h4000, 1, 1, 0, 3'd0, 3'd0);
        chk("pend_bp", dut.u_sb.pending, 8'h02);
        wb(3'd1);
        drive(16'h0000, 0, 1, 0, 3'd0, 3'd0);
        wb_en = 1'b0;
        chk("pend_bp_clr", dut.u_sb.pending, 8'h00);

        wb(3'd4);
        drive(16'h1800, 1, 1, 0, 3'd0, 3'd0);
        wb_en = 1'b0;
        chk("set_wins", dut.u_sb.pending, 8'h10);
        wb(3'd4);
        drive(16'h0000, 0, 1, 0, 3'd0, 3'd0);
        wb_en = 1'b0;
        chk("pend_r4_clr", dut.u_sb.pending, 8'h00);

        drive(16'h1A00, 1, 1, 0, 3'd0, 3'd0);
        chk("pend_r5", dut.u_sb.pending, 8'h20);
        out_ready = 1'b0;
        flush = 1'b1;
        drive(16'h4000, 1, 0, 0, 3'd0, 3'd0);
        flush = 1'b0;
        chk("fl_ov", out_valid, 1'b0);
        chk("fl_pend", dut.u_sb.pending, 8'h00);
        flush = 1'b1;
        drive(16'h1298, 1, 0, 0, 3'd0, 3'd0);
        flush = 1'b0;
        chk("fl_idle_ov", out_valid, 1'b0);
        chk("fl_idle_pend", dut.u_sb.pending, 8'h00);
        out_ready = 1'b1;

        drive(16'h1298, 1, 1, 0, 3'd2, 3'd3);
        for (int k = 0; k < 5; k++)
            drive(16'h2440, 1, 0, 1, 3'd2, 3'd3);
        wb(3'd1);
        drive(16'h2440, 1, 0, 1, 3'd2, 3'd3);
        wb_en = 1'b0;
        drive(16'h2440, 1, 1, 0, 3'd1, 3'd0);
        wb(3'd2);
        drive(16'h0000, 0, 1, 0, 3'd1, 3'd0);
        wb_en = 1'b0;
        chk("end_pend", dut.u_sb.pending, 8'h00);
        chk("drain", exp_q.size(), 0);
`ifdef DECODE_STALL_COUNT_EN
        chk("stall_count", stall_count, stalls);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
